// File: rtl/shift_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_chain_pkg
// Description : Shared types and helpers for the shift_chain delay line.
//               - sc_mode_t : advance mode encoding (shift/rotate/reverse/clear)
//               - popcount  : number of set bits in a (zero-extended) vector
// Revision    : 1.0 - initial release
// ============================================================================
package shift_chain_pkg;

  typedef enum logic [1:0] {
    SC_SHIFT   = 2'd0,
    SC_ROTATE  = 2'd1,
    SC_REVERSE = 2'd2,
    SC_CLEAR   = 2'd3
  } sc_mode_t;

  // popcount operates on a fixed-width vector; callers zero-extend with a
  // size cast so one function serves every DEPTH up to SC_POP_W.
  localparam int SC_POP_W  = 64;
  localparam int SC_POP_CW = 7;

  function automatic logic [SC_POP_CW-1:0] popcount(input logic [SC_POP_W-1:0] v);
    logic [SC_POP_CW-1:0] n;
    n = '0;
    for (int i = 0; i < SC_POP_W; i++) begin
      n = n + SC_POP_CW'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_chain_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_chain_stage
// Description : One chain stage: WIDTH data bits plus a valid bit, loaded
//               from the next-value inputs on every rising edge. The parent
//               supplies the current value when the stage must hold.
// Ports       : clk, rst_n (async, active-low)
//               d_next / vld_next : value to capture
//               d / vld           : registered stage contents
// Revision    : 1.0 - initial release
// ============================================================================
module shift_chain_stage
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_next,
  input  logic             vld_next,
  output logic [WIDTH-1:0] d,
  output logic             vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d   <= '0;
      vld <= 1'b0;
    end else begin
      d   <= d_next;
      vld <= vld_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_chain.sv
`default_nettype none
// ============================================================================
// Module      : shift_chain
// Description : Parametrised multi-stage shift register with per-stage valid
//               bits, shift/rotate/reverse/clear advance modes, parallel load
//               (priority over advance), registered occupancy count and a
//               combinational tap selector.
// Ports       : clk, rst_n (async, active-low)
//               en, mode, din, din_vld     : advance control and serial input
//               load, load_data            : parallel load (stage i at [i*WIDTH +: WIDTH])
//               sel                        : tap select for dout/dout_vld
//               taps, tap_vld              : all stage contents / valid bits
//               dout, dout_vld             : selected stage (0 when sel >= DEPTH)
//               count, full, empty         : occupancy of the valid vector
// Revision    : 1.0 - initial release
// ============================================================================
module shift_chain
  import shift_chain_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_vld,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic [SW-1:0]          sel,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_vld,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_vld,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty
);

  sc_mode_t         w_mode;
  logic [WIDTH-1:0] r_stage_d [DEPTH];
  logic [DEPTH-1:0] r_stage_v;
  logic [DEPTH-1:0] w_next_vld;
  logic [CW-1:0]    r_count;

  assign w_mode = sc_mode_t'(mode);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Neighbour indices wrap so ROTATE can reuse them; SHIFT/REVERSE replace
    // the wrapped end with din instead.
    localparam int PREV = (i == 0)         ? DEPTH - 1 : i - 1;
    localparam int NEXT = (i == DEPTH - 1) ? 0         : i + 1;

    logic [WIDTH-1:0] w_nd;
    logic             w_nv;

    // Every stage reads only old neighbour values, so the chain cannot
    // collapse into a single edge.
    always_comb begin
      w_nd = r_stage_d[i];
      w_nv = r_stage_v[i];
      if (load) begin
        w_nd = load_data[i*WIDTH +: WIDTH];
        w_nv = 1'b1;
      end else if (en) begin
        case (w_mode)
          SC_SHIFT: begin
            if (i == 0) begin
              w_nd = din;
              w_nv = din_vld;
            end else begin
              w_nd = r_stage_d[PREV];
              w_nv = r_stage_v[PREV];
            end
          end
          SC_ROTATE: begin
            w_nd = r_stage_d[PREV];
            w_nv = r_stage_v[PREV];
          end
          SC_REVERSE: begin
            if (i == DEPTH - 1) begin
              w_nd = din;
              w_nv = din_vld;
            end else begin
              w_nd = r_stage_d[NEXT];
              w_nv = r_stage_v[NEXT];
            end
          end
          SC_CLEAR: begin
            w_nd = '0;
            w_nv = 1'b0;
          end
          default: begin
            w_nd = r_stage_d[i];
            w_nv = r_stage_v[i];
          end
        endcase
      end
    end

    assign w_next_vld[i] = w_nv;

    shift_chain_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .d_next   (w_nd),
      .vld_next (w_nv),
      .d        (r_stage_d[i]),
      .vld      (r_stage_v[i])
    );

    assign taps[i*WIDTH +: WIDTH] = r_stage_d[i];
  end

  assign tap_vld = r_stage_v;

  // count tracks the valid vector it is registered alongside, so it can
  // never drift from tap_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= CW'(popcount(SC_POP_W'(w_next_vld)));
    end
  end

  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  // Compare against each legal index so an out-of-range sel (non-power-of-two
  // DEPTH) falls through to zero.
  always_comb begin
    dout     = '0;
    dout_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SW'(i)) begin
        dout     = r_stage_d[i];
        dout_vld = r_stage_v[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_chain
// Description : Self-checking bench for shift_chain. Drives a DEPTH=4 and a
//               DEPTH=3 instance with shared control and compares both
//               against queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_chain;
  import shift_chain_pkg::*;

  typedef struct packed {
    logic [3:0] d;
    logic       v;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  sc_mode_t   mode;
  logic [3:0] din;
  logic       din_vld;
  logic       load;
  logic [15:0] ld4;
  logic [11:0] ld3;
  logic [1:0]  sel4;
  logic [1:0]  sel3;

  logic [15:0] taps4;
  logic [3:0]  tap_vld4;
  logic [3:0]  dout4;
  logic        dout_vld4;
  logic [2:0]  count4;
  logic        full4;
  logic        empty4;

  logic [11:0] taps3;
  logic [2:0]  tap_vld3;
  logic [3:0]  dout3;
  logic        dout_vld3;
  logic [1:0]  count3;
  logic        full3;
  logic        empty3;

  int n_cmp;
  int n_err;

  ent_t mq [2][$];

  shift_chain #(.WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din), .din_vld(din_vld),
    .load(load), .load_data(ld4), .sel(sel4), .taps(taps4), .tap_vld(tap_vld4),
    .dout(dout4), .dout_vld(dout_vld4), .count(count4), .full(full4), .empty(empty4)
  );

  shift_chain #(.WIDTH(4), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din), .din_vld(din_vld),
    .load(load), .load_data(ld3), .sel(sel3), .taps(taps3), .tap_vld(tap_vld3),
    .dout(dout3), .dout_vld(dout_vld3), .count(count3), .full(full3), .empty(empty3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = {};
      for (int i = 0; i < depth_of(k); i++) mq[k].push_back('0);
    end
  endtask

  // Apply one clock edge of behaviour to both models from the current inputs.
  task automatic model_edge();
    ent_t e;
    logic [15:0] ld;
    for (int k = 0; k < 2; k++) begin
      ld = (k == 0) ? ld4 : 16'(ld3);
      if (load) begin
        for (int i = 0; i < depth_of(k); i++) mq[k][i] = '{d: ld[i*4 +: 4], v: 1'b1};
      end else if (en) begin
        e = '{d: din, v: din_vld};
        case (mode)
          SC_SHIFT: begin
            mq[k].push_front(e);
            void'(mq[k].pop_back());
          end
          SC_ROTATE: begin
            e = mq[k].pop_back();
            mq[k].push_front(e);
          end
          SC_REVERSE: begin
            mq[k].push_back(e);
            void'(mq[k].pop_front());
          end
          default: begin
            for (int i = 0; i < depth_of(k); i++) mq[k][i] = '0;
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] et, at;
    logic [3:0]  ev, av, ed, ad;
    logic        edv, adv;
    int          cnt, dep, s, ac;
    logic        af, ae;
    for (int k = 0; k < 2; k++) begin
      dep = depth_of(k);
      et = '0; ev = '0; cnt = 0;
      for (int i = 0; i < dep; i++) begin
        et[i*4 +: 4] = mq[k][i].d;
        ev[i]        = mq[k][i].v;
        cnt         += int'(mq[k][i].v);
      end
      if (k == 0) begin
        at = taps4; av = tap_vld4; ac = int'(count4); af = full4; ae = empty4;
        ad = dout4; adv = dout_vld4; s = int'(sel4);
      end else begin
        at = 16'(taps3); av = 4'(tap_vld3); ac = int'(count3); af = full3; ae = empty3;
        ad = dout3; adv = dout_vld3; s = int'(sel3);
      end
      ed  = (s < dep) ? mq[k][s].d : 4'd0;
      edv = (s < dep) ? mq[k][s].v : 1'b0;
      check($sformatf("taps_d%0d", dep),     64'(at),  64'(et));
      check($sformatf("tap_vld_d%0d", dep),  64'(av),  64'(ev));
      check($sformatf("count_d%0d", dep),    64'(ac),  64'(cnt));
      check($sformatf("full_d%0d", dep),     64'(af),  64'(cnt == dep));
      check($sformatf("empty_d%0d", dep),    64'(ae),  64'(cnt == 0));
      check($sformatf("dout_d%0d", dep),     64'(ad),  64'(ed));
      check($sformatf("dout_vld_d%0d", dep), 64'(adv), 64'(edv));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; en = 1'b0; mode = SC_SHIFT; din = '0; din_vld = 1'b0;
    load = 1'b0; ld4 = '0; ld3 = '0; sel4 = '0; sel3 = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // SHIFT ordering and no-collapse
    en = 1'b1; mode = SC_SHIFT; din_vld = 1'b1;
    din = 4'd5; step();
    check("no_collapse_stage1", 64'(taps4[7:4]), 64'd0);
    din = 4'd6; step();
    din = 4'd7; step();
    din = 4'd8; step();
    check("shift_order", 64'(taps4), 64'h5678);
    check("shift_full", 64'(full4), 64'd1);

    // Asynchronous reset mid-stream with a full chain
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_rst_count", 64'(count4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ROTATE
    load = 1'b1; ld4 = 16'h4321; ld3 = 12'h321; step();
    load = 1'b0; en = 1'b1; mode = SC_ROTATE; step();
    check("rotate_once", 64'(taps4), 64'h3214);
    load = 1'b1; step();
    load = 1'b0;
    repeat (4) step();
    check("rotate_four", 64'(taps4), 64'h4321);
    check("rotate_count", 64'(count4), 64'd4);

    // REVERSE with an invalid push
    mode = SC_REVERSE; din = 4'd9; din_vld = 1'b0; step();
    check("reverse_taps", 64'(taps4), 64'h9432);
    check("reverse_vld", 64'(tap_vld4), 64'b0111);
    check("reverse_count", 64'(count4), 64'd3);

    // load beats en+CLEAR, then CLEAR alone
    load = 1'b1; en = 1'b1; mode = SC_CLEAR; ld4 = 16'hA5C3; ld3 = 12'h7E1; step();
    check("prio_count", 64'(count4), 64'd4);
    load = 1'b0; step();
    check("clear_empty", 64'(empty4), 64'd1);

    // Hold with en=0
    load = 1'b1; ld4 = 16'h1F2E; ld3 = 12'hB6D; step();
    load = 1'b0; en = 1'b0; mode = SC_SHIFT; din_vld = 1'b1;
    repeat (5) step();

    // Tap sweep including out-of-range select on DEPTH=3
    for (int s = 0; s < 4; s++) begin
      sel3 = 2'(s); sel4 = 2'(s);
      #1;
      check_all();
    end
    check("sel_oob_dout", 64'(dout3), 64'd0);
    check("sel_oob_vld", 64'(dout_vld3), 64'd0);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      en      = 1'($urandom_range(0, 3) != 0);
      mode    = sc_mode_t'($urandom_range(0, 3));
      din     = 4'($urandom);
      din_vld = 1'($urandom);
      load    = ($urandom_range(0, 9) == 0);
      ld4     = 16'($urandom);
      ld3     = 12'($urandom);
      sel4    = 2'($urandom_range(0, 3));
      sel3    = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_chain.md
# shift_chain

Parametrised multi-stage shift register with per-stage valid tracking, selectable shift/rotate/reverse/clear modes, parallel load and a tap selector. It generalises the fixed four-register `d0→d1→d2→d3` chain into a reusable delay-line/alignment primitive for datapath blocks. Every stage captures the previous value of its neighbour, so the chain never collapses on an edge.

## Interface
- `WIDTH`, 4, data bits per stage (≥1)
- `DEPTH`, 4, number of stages (≥2)
- `SW`, `$clog2(DEPTH)`, tap-select width (derived, not overridden)
- `CW`, `$clog2(DEPTH+1)`, occupancy-count width (derived)

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  advance the chain this cycle
- `mode`  in  2  0=SHIFT, 1=ROTATE, 2=REVERSE, 3=CLEAR
- `din`  in  WIDTH  serial input data
- `din_vld`  in  1  valid qualifier for `din`
- `load`  in  1  parallel load request
- `load_data`  in  WIDTH*DEPTH  stage i at `[i*WIDTH +: WIDTH]`
- `sel`  in  SW  tap select
- `taps`  out  WIDTH*DEPTH  all stage registers, stage i at `[i*WIDTH +: WIDTH]`
- `tap_vld`  out  DEPTH  per-stage valid bits
- `dout`  out  WIDTH  stage[`sel`], combinational mux
- `dout_vld`  out  1  `tap_vld[sel]`
- `count`  out  CW  number of set valid bits, registered
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`

## Operation
- Reset: all stages 0, all valid bits 0, `count`=0. Consequently `empty`=1, `full`=0, `dout`=0, `dout_vld`=0.
- Priority on each edge: `load` > `en`. With neither asserted, all state holds.
- `load`=1: stage i ← `load_data[i]`; all valid bits ← 1; `count` ← DEPTH. `mode` is ignored.
- `en`=1, SHIFT: stage0 ← `din`, valid0 ← `din_vld`; stage i ← old stage i-1, for i = 1..DEPTH-1. Old stage DEPTH-1 is discarded.
- `en`=1, ROTATE: stage0 ← old stage DEPTH-1; stage i ← old stage i-1. Valid bits rotate identically. `din` is ignored and `count` is unchanged.
- `en`=1, REVERSE: stage DEPTH-1 ← `din`, valid ← `din_vld`; stage i ← old stage i+1. Old stage0 is discarded.
- `en`=1, CLEAR: all stages and valid bits ← 0; `count` ← 0.
- Data moves regardless of valid bits. Invalid stages shift their data like any other stage.
- `count` is the popcount of the next-state valid vector, registered with it. It is never incremented or decremented separately.
- `sel` ≥ DEPTH (non-power-of-two DEPTH): `dout`=0, `dout_vld`=0.

## Timing
- Single-cycle update: the effect of a load or advance is visible on `taps`/`tap_vld`/`count` after the same rising edge.
- `dout`/`dout_vld` follow `sel` combinationally, with zero latency.
- Latency from `din` to stage k in SHIFT is k+1 enabled edges. `din` reaches stage DEPTH-1 after DEPTH enabled edges.
- `full`/`empty` are decoded from registered `count`; both change on the same edge as `count`.
- `rst_n` asserted mid-operation clears all state immediately, without waiting for `clk`. Release is synchronised upstream.
- Simultaneous `load`+`en`+CLEAR: load wins, so the chain ends up full.

## Structure
- `shift_chain_pkg` holds:
  - the mode constants `SC_SHIFT`, `SC_ROTATE`, `SC_REVERSE`, `SC_CLEAR` as a 2-bit enum typedef `sc_mode_t`;
  - a `popcount` function used by `count`.
- Sub-module `shift_chain_stage` is one WIDTH+1-bit register: data plus valid, with async reset and a next-value input. `shift_chain` generates DEPTH instances and computes each instance's next value from mode/neighbours.

## Test plan
- Reset check: WIDTH=4, DEPTH=4. Reset → `taps`=0, `tap_vld`=0000, `count`=0, `empty`=1. Assert reset mid-stream with the chain full → all outputs return to reset values before the next edge.
- SHIFT order: `din`=5,6,7,8 with `din_vld`=1 over 4 enabled edges.
  - Stage0..3 = 8,7,6,5; `full`=1.
  - After edge 1, stage1 = 0, not 5, which proves no chain collapse.
- ROTATE: load 1,2,3,4 into stages 0..3, then 1 rotate → stages = 4,1,2,3. Rotate 4 times → 1,2,3,4; `count` stays 4.
- REVERSE with valid holes: start from the full chain. Push `din`=9 with `din_vld`=0 → stage3=9, `tap_vld`=0111, `count`=3.
- Priority: `load`=1 with `en`=1 and `mode`=CLEAR → `load_data` is loaded and `count`=4. Next cycle, CLEAR alone → `count`=0, `empty`=1.
- Tap select: DEPTH=3 build. Sweep `sel` 0..3; `sel`=3 → `dout`=0, `dout_vld`=0. `en`=0 for 5 edges → state unchanged.
